// File: rtl/tlb_walker.sv
// Four-level, 4 KiB-page table walker sitting behind the TLB. It runs one walk
// at a time over a single-outstanding PTE read port and ends each walk with a
// one-cycle refill or fault strobe.
module tlb_walker #(
   parameter int unsigned VA_W   = 64,
   parameter int unsigned PA_W   = 64,
   parameter int unsigned PCID_W = 12
) (
   input  logic              clk,
   input  logic              shutdown,
   input  logic              miss,
   input  logic [VA_W-1:0]   va,
   input  logic [PCID_W-1:0] pcid,
   input  logic [PA_W-1:0]   cr3,
   output logic              busy,
   output logic              mem_req,
   output logic [PA_W-1:0]   mem_addr,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [63:0]       mem_rdata,
   output logic              insert,
   output logic [VA_W-1:0]   ins_va,
   output logic [PA_W-1:0]   ins_pa,
   output logic [PCID_W-1:0] ins_pcid,
   output logic              fault
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_e;

   state_e            state_q;
   logic [1:0]        level_q;
   logic [VA_W-1:0]   va_q;
   logic [PCID_W-1:0] pcid_q;
   logic [PA_W-1:0]   mem_addr_q;
   logic [PA_W-1:0]   ins_pa_q;
   logic              busy_q;
   logic              mem_req_q;
   logic              insert_q;
   logic              fault_q;
   logic              canonical;
   logic              unused_ok;

   assign canonical = (va[63:47] == '0) || (va[63:47] == '1);

   // The table base is 4 KiB aligned and the scaled index is below 4 KiB,
   // so the add reduces to a concatenation.
   function automatic logic [PA_W-1:0] pte_addr(input logic [39:0] base,
                                                input logic [35:0] vpn,
                                                input logic [1:0]  lvl);
      logic [8:0] idx;
      case (lvl)
         2'd3:    idx = vpn[35:27];
         2'd2:    idx = vpn[26:18];
         2'd1:    idx = vpn[17:9];
         default: idx = vpn[8:0];
      endcase
      return PA_W'({base, idx, 3'b000});
   endfunction

   always_ff @(posedge clk or posedge shutdown) begin
      if (shutdown) begin
         state_q    <= IDLE;
         level_q    <= '0;
         va_q       <= '0;
         pcid_q     <= '0;
         mem_addr_q <= '0;
         ins_pa_q   <= '0;
         busy_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         insert_q   <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         insert_q <= 1'b0;
         fault_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (miss) begin
                  va_q    <= va;
                  pcid_q  <= pcid;
                  level_q <= 2'd3;
                  busy_q  <= 1'b1;
                  if (!canonical) begin
                     fault_q <= 1'b1;
                     state_q <= FAULT;
                  end else begin
                     mem_addr_q <= pte_addr(cr3[51:12], va[47:12], 2'd3);
                     mem_req_q  <= 1'b1;
                     state_q    <= REQ;
                  end
               end
            end
            REQ: begin
               if (mem_ready) begin
                  mem_req_q <= 1'b0;
                  state_q   <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  if (!mem_rdata[0]) begin
                     fault_q <= 1'b1;
                     state_q <= FAULT;
                  end else if (level_q != 2'd0) begin
                     level_q    <= level_q - 2'd1;
                     mem_addr_q <= pte_addr(mem_rdata[51:12], va_q[47:12], level_q - 2'd1);
                     mem_req_q  <= 1'b1;
                     state_q    <= REQ;
                  end else begin
                     ins_pa_q <= PA_W'({mem_rdata[51:12], va_q[11:0]});
                     insert_q <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            DONE, FAULT: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q    <= 1'b0;
               mem_req_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign insert   = insert_q;
   assign fault    = fault_q;
   assign ins_va   = {va_q[VA_W-1:12], 12'h000};
   assign ins_pa   = ins_pa_q;
   assign ins_pcid = pcid_q;

   // PTE attribute bits and the untranslated parts of cr3 play no role.
   assign unused_ok = ^{cr3[PA_W-1:52], cr3[11:0], mem_rdata[63:52], mem_rdata[11:1]};

endmodule

// File: tb/tb_tlb_walker.sv
// Randomized bench for tlb_walker: a sparse page-table memory answers PTE reads
// and a reference walk model predicts addresses, outcome and strobe timing.
module tb_tlb_walker;

   logic        clk = 1'b0;
   logic        shutdown, miss, mem_ready, mem_rvalid;
   logic [63:0] va, cr3, mem_rdata;
   logic [11:0] pcid;
   logic        busy, mem_req, insert, fault;
   logic [63:0] mem_addr, ins_va, ins_pa;
   logic [11:0] ins_pcid;

   tlb_walker #(.VA_W(64), .PA_W(64), .PCID_W(12)) dut (
      .clk(clk), .shutdown(shutdown), .miss(miss), .va(va), .pcid(pcid), .cr3(cr3),
      .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .insert(insert), .ins_va(ins_va),
      .ins_pa(ins_pa), .ins_pcid(ins_pcid), .fault(fault)
   );

   always #5 clk = ~clk;

   bit [63:0]   pt[bit [63:0]];
   int          vectors = 0;
   int          miscompares = 0;

   logic [63:0] ob_addr[$];
   int          ob_ins_cyc, ob_flt_cyc, ob_unstable, ob_busy_bad, ob_tail_bad, ob_strobes;
   logic [63:0] ob_ins_va, ob_ins_pa;
   logic [11:0] ob_ins_pcid;

   int          stall[4], rdly[4];
   bit          spur_rvalid;
   int          midmiss_cyc;
   logic [63:0] midmiss_va;

   bit [63:0]   ex_addr[$];
   bit          ex_fault;
   bit [63:0]   ex_pa;

   localparam bit [63:0] PFN_MASK = 64'h000F_FFFF_FFFF_F000;

   function automatic void model_walk(input bit [63:0] v, input bit [63:0] c);
      longint    top;
      bit [63:0] base, a, pte;
      ex_addr.delete();
      ex_fault = 1'b0;
      ex_pa    = '0;
      top = $signed(v) >>> 47;
      if (top != 0 && top != -1) begin
         ex_fault = 1'b1;
         return;
      end
      base = c & PFN_MASK;
      for (int lvl = 3; lvl >= 0; lvl--) begin
         a = base + ((v >> (12 + 9 * lvl)) & 64'h1FF) * 8;
         ex_addr.push_back(a);
         pte = pt.exists(a) ? pt[a] : 64'h0;
         if (pte[0] == 1'b0) begin
            ex_fault = 1'b1;
            return;
         end
         base = pte & PFN_MASK;
      end
      ex_pa = base | (v & 64'hFFF);
   endfunction

   function automatic int model_latency();
      int n = 1;
      for (int i = 0; i < ex_addr.size(); i++) n += 2 + stall[i] + rdly[i];
      return n;
   endfunction

   task automatic clear_opts();
      for (int i = 0; i < 4; i++) begin
         stall[i] = 0;
         rdly[i]  = 0;
      end
      spur_rvalid = 1'b0;
      midmiss_cyc = -1;
      midmiss_va  = '0;
   endtask

   task automatic load_spec_table();
      pt.delete();
      pt[64'h1008] = 64'h2001;
      pt[64'h2008] = 64'h3001;
      pt[64'h3008] = 64'h4001;
      pt[64'h4008] = 64'h0ABC_D003;
   endtask

   // Issues one miss, plays the memory side and records what the walker did.
   task automatic drive_walk(input logic [63:0] v, input logic [11:0] p, input logic [63:0] c);
      int          cyc, wait_left, stall_left, nreq;
      bit          in_req, pend, done;
      logic [63:0] cur, raddr;
      ob_addr.delete();
      ob_ins_cyc = -1; ob_flt_cyc = -1; ob_unstable = 0;
      ob_busy_bad = 0; ob_tail_bad = 0; ob_strobes = 0;
      in_req = 0; pend = 0; done = 0; nreq = 0;
      wait_left = 0; stall_left = 0; cur = '0; raddr = '0;
      @(negedge clk);
      miss = 1'b1; va = v; pcid = p; cr3 = c;
      @(negedge clk);
      va = {$urandom, $urandom}; cr3 = {$urandom, $urandom}; pcid = 12'($urandom);
      cyc = 1;
      while (!done) begin
         miss = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
         mem_rdata = {$urandom, $urandom};
         if (busy !== 1'b1) ob_busy_bad++;
         if (insert === 1'b1 || fault === 1'b1) begin
            ob_strobes++;
            if (insert === 1'b1) ob_ins_cyc = cyc;
            if (fault === 1'b1) ob_flt_cyc = cyc;
            ob_ins_va = ins_va; ob_ins_pa = ins_pa; ob_ins_pcid = ins_pcid;
            done = 1;
         end else if (pend) begin
            if (mem_req !== 1'b0) ob_unstable++;
            if (wait_left == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = pt.exists(raddr) ? pt[raddr] : 64'h0;
               pend = 0;
            end else wait_left--;
         end else if (mem_req === 1'b1) begin
            if (!in_req) begin
               in_req = 1; cur = mem_addr; ob_addr.push_back(mem_addr);
               stall_left = stall[nreq & 3];
            end else if (mem_addr !== cur) ob_unstable++;
            if (stall_left == 0) begin
               mem_ready = 1'b1; pend = 1; wait_left = rdly[nreq & 3];
               raddr = cur; in_req = 0; nreq++;
            end else begin
               stall_left--;
               if (spur_rvalid) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = 64'h0;
               end
            end
         end
         if (cyc == midmiss_cyc) begin
            miss = 1'b1; va = midmiss_va;
         end
         if (cyc > 400) begin
            vectors++; miscompares++;
            $display("FAIL walk_timeout: no insert/fault after %0d cycles, want a strobe", cyc);
            done = 1;
         end
         @(negedge clk);
         cyc++;
      end
      miss = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (busy !== 1'b0 || insert !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0) ob_tail_bad++;
   endtask

   task automatic test_reset();
      shutdown = 1'b1; miss = 1'b0; va = '0; pcid = '0; cr3 = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      vectors++; if (insert !== 1'b0 || fault !== 1'b0) begin miscompares++; $display("FAIL reset_strobes: got insert=%b fault=%b want 0/0", insert, fault); end
      vectors++; if (mem_addr !== 64'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      vectors++; if ({ins_va, ins_pa, ins_pcid} !== '0) begin miscompares++; $display("FAIL reset_ins: got va=%h pa=%h pcid=%h want 0", ins_va, ins_pa, ins_pcid); end
      @(negedge clk);
      @(negedge clk);
      shutdown = 1'b0;
   endtask

   task automatic test_full_walk();
      logic [63:0] want[4];
      logic [63:0] got;
      want = '{64'h1008, 64'h2008, 64'h3008, 64'h4008};
      load_spec_table(); clear_opts();
      drive_walk(64'h0000_0080_4020_1ABC, 12'd5, 64'h1000);
      vectors++; if (ob_addr.size() != 4) begin miscompares++; $display("FAIL full_req_count: got %0d want 4", ob_addr.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < ob_addr.size()) ? ob_addr[i] : 'x;
         vectors++; if (got !== want[i]) begin miscompares++; $display("FAIL full_addr%0d: got %h want %h", i, got, want[i]); end
      end
      vectors++; if (ob_ins_cyc != 9) begin miscompares++; $display("FAIL full_insert_cycle: got %0d want 9", ob_ins_cyc); end
      vectors++; if (ob_ins_va !== 64'h0000_0080_4020_1000) begin miscompares++; $display("FAIL full_ins_va: got %h want 0000008040201000", ob_ins_va); end
      vectors++; if (ob_ins_pa !== 64'h0ABC_DABC) begin miscompares++; $display("FAIL full_ins_pa: got %h want 000000000abcdabc", ob_ins_pa); end
      vectors++; if (ob_ins_pcid !== 12'd5) begin miscompares++; $display("FAIL full_ins_pcid: got %0d want 5", ob_ins_pcid); end
      vectors++; if (ob_busy_bad != 0 || ob_tail_bad != 0) begin miscompares++; $display("FAIL full_busy: got busy_gaps=%0d tail_errs=%0d want 0/0", ob_busy_bad, ob_tail_bad); end
   endtask

   task automatic test_not_present();
      load_spec_table(); clear_opts();
      pt[64'h3008] = 64'h4000;
      drive_walk(64'h0000_0080_4020_1ABC, 12'd5, 64'h1000);
      vectors++; if (ob_addr.size() != 3) begin miscompares++; $display("FAIL np_req_count: got %0d want 3", ob_addr.size()); end
      vectors++; if (ob_flt_cyc != 7 || ob_ins_cyc != -1) begin miscompares++; $display("FAIL np_outcome: got fault_cyc=%0d insert_cyc=%0d want 7/-1", ob_flt_cyc, ob_ins_cyc); end
      vectors++; if (ob_strobes != 1 || ob_tail_bad != 0) begin miscompares++; $display("FAIL np_single_pulse: got strobes=%0d tail_errs=%0d want 1/0", ob_strobes, ob_tail_bad); end
   endtask

   task automatic test_noncanonical();
      load_spec_table(); clear_opts();
      drive_walk(64'h8000_0000_0000_0000, 12'd9, 64'h1000);
      vectors++; if (ob_addr.size() != 0) begin miscompares++; $display("FAIL nc_no_request: got %0d requests want 0", ob_addr.size()); end
      vectors++; if (ob_flt_cyc != 1 || ob_ins_cyc != -1) begin miscompares++; $display("FAIL nc_fault_cycle: got fault_cyc=%0d insert_cyc=%0d want 1/-1", ob_flt_cyc, ob_ins_cyc); end
      vectors++; if (ob_ins_va !== 64'h8000_0000_0000_0000 || ob_ins_pcid !== 12'd9) begin miscompares++; $display("FAIL nc_fault_info: got va=%h pcid=%0d want 8000000000000000/9", ob_ins_va, ob_ins_pcid); end
   endtask

   task automatic test_backpressure();
      load_spec_table(); clear_opts();
      stall[0] = 3;
      drive_walk(64'h0000_0080_4020_1ABC, 12'd5, 64'h1000);
      vectors++; if (ob_ins_cyc != 12) begin miscompares++; $display("FAIL bp_insert_cycle: got %0d want 12", ob_ins_cyc); end
      vectors++; if (ob_unstable != 0) begin miscompares++; $display("FAIL bp_req_stable: got %0d changes want 0", ob_unstable); end
      vectors++; if (ob_addr.size() == 0 || ob_addr[0] !== 64'h1008) begin miscompares++; $display("FAIL bp_first_addr: got %h want 1008", ob_addr.size() ? ob_addr[0] : 64'h0); end
   endtask

   task automatic test_miss_while_busy();
      load_spec_table(); clear_opts();
      stall[1] = 2; spur_rvalid = 1'b1;
      midmiss_cyc = 3; midmiss_va = 64'h0000_1234_5678_9000;
      drive_walk(64'h0000_0080_4020_1ABC, 12'd7, 64'h1000);
      vectors++; if (ob_ins_cyc != 11 || ob_flt_cyc != -1) begin miscompares++; $display("FAIL mwb_outcome: got insert_cyc=%0d fault_cyc=%0d want 11/-1", ob_ins_cyc, ob_flt_cyc); end
      vectors++; if (ob_ins_va !== 64'h0000_0080_4020_1000 || ob_ins_pcid !== 12'd7) begin miscompares++; $display("FAIL mwb_ins_va: got %h/%0d want 0000008040201000/7", ob_ins_va, ob_ins_pcid); end
      vectors++; if (ob_addr.size() != 4 || ob_tail_bad != 0) begin miscompares++; $display("FAIL mwb_no_extra_walk: got reqs=%0d tail_errs=%0d want 4/0", ob_addr.size(), ob_tail_bad); end
   endtask

   task automatic test_reset_midwalk();
      load_spec_table(); clear_opts();
      @(negedge clk);
      miss = 1'b1; va = 64'h0000_0080_4020_1ABC; pcid = 12'd5; cr3 = 64'h1000;
      @(negedge clk); miss = 1'b0; mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h2001;
      @(negedge clk); mem_rvalid = 1'b0; mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      shutdown = 1'b1;
      #1;
      vectors++; if ({busy, mem_req, insert, fault} !== 4'b0) begin miscompares++; $display("FAIL rst_mid_ctrl: got busy/req/ins/flt=%b want 0000", {busy, mem_req, insert, fault}); end
      vectors++; if ({mem_addr, ins_va, ins_pa, ins_pcid} !== '0) begin miscompares++; $display("FAIL rst_mid_data: got addr=%h va=%h pa=%h want 0", mem_addr, ins_va, ins_pa); end
      mem_rvalid = 1'b1; mem_rdata = 64'h3001;
      @(negedge clk); shutdown = 1'b0;
      @(negedge clk); mem_rvalid = 1'b0;
      vectors++; if ({busy, mem_req, insert, fault} !== 4'b0) begin miscompares++; $display("FAIL rst_late_resp: got busy/req/ins/flt=%b want 0000", {busy, mem_req, insert, fault}); end
      drive_walk(64'h0000_0080_4020_1ABC, 12'd5, 64'h1000);
      vectors++; if (ob_addr.size() == 0 || ob_addr[0] !== 64'h1008 || ob_ins_cyc != 9) begin miscompares++; $display("FAIL rst_fresh_walk: got addr0=%h insert_cyc=%0d want 1008/9", ob_addr.size() ? ob_addr[0] : 64'h0, ob_ins_cyc); end
   endtask

   task automatic test_random();
      bit [63:0]   v, c, base, a, pte;
      logic [11:0] p;
      logic [63:0] got;
      int          exp_cyc;
      for (int n = 0; n < 40; n++) begin
         pt.delete(); clear_opts();
         for (int i = 0; i < 4; i++) begin
            stall[i] = $urandom_range(0, 2);
            rdly[i]  = $urandom_range(0, 2);
         end
         c = {$urandom, $urandom};
         v = {$urandom, $urandom};
         v[63:47] = v[47] ? '1 : '0;
         if ($urandom_range(0, 5) == 0) v[60] = ~v[60];
         p = 12'($urandom);
         base = c & PFN_MASK;
         for (int lvl = 3; lvl >= 0; lvl--) begin
            a = base + ((v >> (12 + 9 * lvl)) & 64'h1FF) * 8;
            pte = {$urandom, $urandom};
            pte[0] = ($urandom_range(0, 9) != 0);
            pt[a] = pte;
            base = pte & PFN_MASK;
         end
         model_walk(v, c);
         exp_cyc = model_latency();
         drive_walk(v, p, c);
         vectors++; if (ob_addr.size() != ex_addr.size()) begin miscompares++; $display("FAIL rnd%0d_req_count: got %0d want %0d", n, ob_addr.size(), ex_addr.size()); end
         for (int i = 0; i < ex_addr.size(); i++) begin
            got = (i < ob_addr.size()) ? ob_addr[i] : 'x;
            vectors++; if (got !== ex_addr[i]) begin miscompares++; $display("FAIL rnd%0d_addr%0d: got %h want %h", n, i, got, ex_addr[i]); end
         end
         vectors++;
         if ((ex_fault ? ob_flt_cyc : ob_ins_cyc) != exp_cyc || ob_strobes != 1) begin
            miscompares++;
            $display("FAIL rnd%0d_outcome: got insert_cyc=%0d fault_cyc=%0d want %s at %0d", n, ob_ins_cyc, ob_flt_cyc, ex_fault ? "fault" : "insert", exp_cyc);
         end
         vectors++; if (ob_ins_va !== {v[63:12], 12'h0} || ob_ins_pcid !== p) begin miscompares++; $display("FAIL rnd%0d_ins_va: got %h/%h want %h/%h", n, ob_ins_va, ob_ins_pcid, {v[63:12], 12'h0}, p); end
         if (!ex_fault) begin
            vectors++; if (ob_ins_pa !== ex_pa) begin miscompares++; $display("FAIL rnd%0d_ins_pa: got %h want %h", n, ob_ins_pa, ex_pa); end
         end
         vectors++; if (ob_unstable + ob_busy_bad + ob_tail_bad != 0) begin miscompares++; $display("FAIL rnd%0d_protocol: got unstable=%0d busy_gaps=%0d tail_errs=%0d want 0", n, ob_unstable, ob_busy_bad, ob_tail_bad); end
      end
   endtask

   initial begin
      test_reset();
      test_full_walk();
      test_not_present();
      test_noncanonical();
      test_backpressure();
      test_miss_while_busy();
      test_reset_midwalk();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tlb_walker.md
# tlb_walker

Hardware page-table walker that sits directly downstream of the set-associative TLB (`cache`). It accepts a TLB miss (VA + PCID) and walks a 4-level, 4 KiB-page table through a single-outstanding memory read port. It then either drives a one-cycle refill (`insert`, `ins_va`, `ins_pa`, `ins_pcid`) back into the TLB or reports a translation fault. Only one walk is in flight at a time.

## Interface
- `VA_W`, 64, virtual address width
- `PA_W`, 64, physical address / memory address width
- `PCID_W`, 12, process-context ID width
- `clk`  in  1  clock, rising edge
- `shutdown`  in  1  asynchronous, active-high reset
- `miss`  in  1  TLB miss for `va`/`pcid`; sampled only in IDLE
- `va`  in  VA_W  virtual address that missed
- `pcid`  in  PCID_W  PCID of the missing access
- `cr3`  in  PA_W  root table base; bits [51:12] used; sampled with `miss`
- `busy`  out  1  high in every state except IDLE
- `mem_req`  out  1  PTE read request valid
- `mem_addr`  out  PA_W  PTE physical address, 8-byte aligned
- `mem_ready`  in  1  memory accepts request when `mem_req && mem_ready`
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  64  PTE read data
- `insert`  out  1  one-cycle TLB refill strobe
- `ins_va`  out  VA_W  refill VA, page-aligned: {va[63:12], 12'h0}
- `ins_pa`  out  PA_W  refill PA: {12'h0, pte[51:12], va[11:0]}
- `ins_pcid`  out  PCID_W  refill PCID
- `fault`  out  1  one-cycle translation-fault strobe; `ins_va`/`ins_pcid` valid with it

## Operation
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE: if `miss`=1, latch `va`, `pcid`, and `cr3[51:12]` as base. Set level=3.
  - If `va[63:48]` is not all equal to `va[47]` (non-canonical), go to FAULT and issue no memory access.
  - Otherwise go to REQ.
- Index for level L: L3=va[47:39], L2=va[38:30], L1=va[29:21], L0=va[20:12].
- `mem_addr` = {12'h0, base[51:12], 12'h0} + (index << 3). It is registered and stable for the whole REQ state.
- REQ: `mem_req`=1. Stay in REQ until `mem_ready`=1, then go to WAIT. The request cannot be withdrawn once raised.
- WAIT: `mem_req`=0. Wait for `mem_rvalid`.
  - `pte[0]`=0: go to FAULT.
  - `pte[0]`=1 and level>0: base=pte[51:12], level=level-1, go to REQ.
  - `pte[0]`=1 and level=0: latch `ins_pa`, go to DONE.
- DONE: `insert`=1 for exactly one cycle, then IDLE.
- FAULT: `fault`=1 for exactly one cycle, then IDLE.
- PTE bits [63:52] and [11:1] are ignored. Large pages are not supported: bit 7 is ignored and every walk is 4 levels.
- `mem_rvalid` outside WAIT is ignored.
- `miss` outside IDLE is ignored; there is no queue. After DONE the TLB has taken the refill, so a repeat miss on the same VA is not expected. If one arrives, it starts a new walk.
- `mem_rvalid` in the same cycle as the REQ→WAIT transition is not legal: the response comes at least one cycle after acceptance.

## Timing
- Reset (`shutdown`=1, async): state=IDLE. `busy`, `mem_req`, `insert`, `fault`=0. `mem_addr`, `ins_va`, `ins_pa`, `ins_pcid`=0.
- Reset mid-walk aborts immediately and drops `mem_req`. A memory response that arrives after reset is ignored.
- All outputs are registered or decoded from registered state only. There is no combinational path from input to output.
- Minimum latency, with `mem_ready`=1 and `mem_rvalid` one cycle after acceptance:
  - Miss sampled at edge 0.
  - REQ in cycles 1/3/5/7; WAIT in cycles 2/4/6/8.
  - `insert` is high in cycle 9, which is 9 cycles after the miss edge.
- Each `mem_ready` stall cycle adds 1 cycle; each extra `mem_rvalid` delay cycle adds 1 cycle.
- Non-canonical fault: `fault` is high in cycle 1.
- `busy` rises the cycle after `miss` is accepted and falls in the cycle after DONE/FAULT.

## Test plan
- Full walk. Setup: cr3=0x1000, va=0x0000_0080_4020_1ABC, pcid=5, `mem_ready`=1, `mem_rvalid` one cycle later.
  - PTE responses: 0x2001, 0x3001, 0x4001, 0x0ABC_D003.
  - Required `mem_addr` sequence: 0x1008, 0x2008, 0x3008, 0x4008.
  - Required in cycle 9: `insert`=1, `ins_va`=0x0000_0080_4020_1000, `ins_pa`=0x0ABC_DABC, `ins_pcid`=5.
- Not-present at L1: same setup, but the third PTE is 0x4000.
  - Required: no fourth request; `fault` pulses once; `insert` stays 0.
- Non-canonical VA: va=0x8000_0000_0000_0000.
  - Required: `fault` in cycle 1; `mem_req` never asserted.
- Backpressure: `mem_ready`=0 for 3 cycles on the first request.
  - Required: `mem_req` and `mem_addr`=0x1008 held steady; `insert` arrives 3 cycles later (cycle 12).
- Miss while busy: assert `miss` with a different va mid-walk.
  - Required: the walk completes for the original va only; a spurious `mem_rvalid` in REQ is ignored.
- Reset mid-walk: `shutdown` pulse while in WAIT at L2.
  - Required: all outputs 0 immediately; the next `miss` starts a fresh walk at 0x1008.
